// File: rtl/fetch_unit_if.sv
// IF-stage bus: control inputs from ID/CP0, instruction-memory port and IF/ID fields.
interface fetch_unit_if;
  localparam int unsigned XLEN = 32;
  localparam int unsigned EXCW = 4;

  logic            stall;
  logic            exc_req;
  logic            eret_d;
  logic [XLEN-1:0] epc;
  logic            jmp_d;
  logic            br_taken;
  logic [XLEN-1:0] br_target;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic [XLEN-1:0] pcF;
  logic [XLEN-1:0] insF;
  logic            bdF;
  logic [EXCW-1:0] execF;

  // Fetch unit side.
  modport master (
    input  stall, exc_req, eret_d, epc, jmp_d, br_taken, br_target, imem_rdata,
    output imem_addr, pcF, insF, bdF, execF
  );

  // Pipeline / memory side.
  modport slave (
    output stall, exc_req, eret_d, epc, jmp_d, br_taken, br_target, imem_rdata,
    input  imem_addr, pcF, insF, bdF, execF
  );
endinterface

// File: rtl/fetch_unit.sv
// IF-stage fetch unit: owns the fetch PC, selects next PC, flags fetch faults.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] IMEM_BASE  = 32'h0000_3000,
  parameter logic [31:0] IMEM_LIMIT = 32'h0000_6FFC
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
);
  localparam int unsigned XLEN = 32;
  localparam int unsigned EXCW = 4;
  localparam logic [EXCW-1:0] EXC_NONE = EXCW'(0);
  localparam logic [EXCW-1:0] EXC_ADEL = EXCW'(4);

  logic [XLEN-1:0] pc;
  logic            misaligned;
  logic            out_of_range;
  logic            fetch_fault;

  // Next-PC selection: exception > eret > stall > taken branch > sequential.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (bus.exc_req) begin
      pc <= HANDLER_PC;
    end else if (bus.eret_d) begin
      pc <= bus.epc;
    end else if (bus.stall) begin
      pc <= pc;
    end else if (bus.br_taken) begin
      pc <= bus.br_target;
    end else begin
      pc <= pc + XLEN'(4);
    end
  end

  // Address check on the current PC; a bad redirect target faults here, not at load.
  always_comb begin
    misaligned   = (pc[1:0] != 2'b00);
    out_of_range = (pc < IMEM_BASE) || (pc > IMEM_LIMIT);
    fetch_fault  = misaligned || out_of_range;
  end

  // IF/ID fields; the slot behind eret is squashed and neither faults nor counts as a delay slot.
  always_comb begin
    bus.imem_addr = pc;
    bus.pcF       = pc;
    bus.bdF       = bus.jmp_d & ~bus.eret_d;
    bus.execF     = EXC_NONE;
    bus.insF      = bus.imem_rdata;
    if (bus.eret_d) begin
      bus.insF = '0;
    end else if (fetch_fault) begin
      bus.insF  = '0;
      bus.execF = EXC_ADEL;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed test-plan scenarios plus randomized run.
module tb_fetch_unit;
  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
  localparam logic [31:0] IMEM_BASE  = 32'h0000_3000;
  localparam logic [31:0] IMEM_LIMIT = 32'h0000_6FFC;
  localparam logic [31:0] FIXED_WORD = 32'h2408_0001;

  logic clk;
  logic reset;
  logic fixed_en;
  logic [31:0] mpc;
  int n_cmp;
  int n_bad;

  fetch_unit_if bus ();

  fetch_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: either a constant word or an address-derived pattern.
  always_comb bus.imem_rdata = fixed_en ? FIXED_WORD : (bus.imem_addr ^ 32'hDEAD_BEEF);

  // Reference model helpers.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return fixed_en ? FIXED_WORD : (a ^ 32'hDEAD_BEEF);
  endfunction

  function automatic logic bad_addr(input logic [31:0] a);
    return (a % 4 != 0) || (a < IMEM_BASE) || (a > IMEM_LIMIT);
  endfunction

  function automatic logic [31:0] model_next(input logic [31:0] pc);
    if (reset)        return RESET_PC;
    if (bus.exc_req)  return HANDLER_PC;
    if (bus.eret_d)   return bus.epc;
    if (bus.stall)    return pc;
    if (bus.br_taken) return bus.br_target;
    return pc + 32'd4;
  endfunction

  task automatic idle_inputs();
    reset         = 1'b0;
    bus.stall     = 1'b0;
    bus.exc_req   = 1'b0;
    bus.eret_d    = 1'b0;
    bus.epc       = 32'h0;
    bus.jmp_d     = 1'b0;
    bus.br_taken  = 1'b0;
    bus.br_target = 32'h0;
  endtask

  // Advance one clock, updating the model PC from the inputs held across the edge.
  task automatic tick();
    logic [31:0] nxt;
    nxt = model_next(mpc);
    @(posedge clk);
    #1;
    mpc = nxt;
  endtask

  task automatic goto_pc(input logic [31:0] a);
    idle_inputs();
    bus.br_taken  = 1'b1;
    bus.br_target = a;
    tick();
    idle_inputs();
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    n_cmp++; if (bus.pcF !== RESET_PC) begin n_bad++; $display("FAIL reset_pcF: got %h expected %h", bus.pcF, RESET_PC); end
    n_cmp++; if (bus.imem_addr !== RESET_PC) begin n_bad++; $display("FAIL reset_imem_addr: got %h expected %h", bus.imem_addr, RESET_PC); end
    n_cmp++; if (bus.execF !== 4'd0) begin n_bad++; $display("FAIL reset_execF: got %h expected %h", bus.execF, 4'd0); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc;
    idle_inputs();
    #1;
    exp_pc = 32'h3000;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (bus.pcF !== exp_pc) begin n_bad++; $display("FAIL seq_pcF[%0d]: got %h expected %h", i, bus.pcF, exp_pc); end
      n_cmp++; if (bus.insF !== FIXED_WORD) begin n_bad++; $display("FAIL seq_insF[%0d]: got %h expected %h", i, bus.insF, FIXED_WORD); end
      n_cmp++; if (bus.execF !== 4'd0) begin n_bad++; $display("FAIL seq_execF[%0d]: got %h expected 0", i, bus.execF); end
      tick();
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  task automatic test_branch();
    n_cmp++; if (bus.pcF !== 32'h3010) begin n_bad++; $display("FAIL br_start_pcF: got %h expected 00003010", bus.pcF); end
    bus.br_taken  = 1'b1;
    bus.br_target = 32'h3100;
    bus.jmp_d     = 1'b1;
    #1;
    n_cmp++; if (bus.bdF !== 1'b1) begin n_bad++; $display("FAIL br_bdF: got %b expected 1", bus.bdF); end
    tick();
    idle_inputs();
    #1;
    n_cmp++; if (bus.pcF !== 32'h3100) begin n_bad++; $display("FAIL br_target_pcF: got %h expected 00003100", bus.pcF); end
    n_cmp++; if (bus.bdF !== 1'b0) begin n_bad++; $display("FAIL br_bdF_clear: got %b expected 0", bus.bdF); end
    tick();
    n_cmp++; if (bus.pcF !== 32'h3104) begin n_bad++; $display("FAIL br_seq_pcF: got %h expected 00003104", bus.pcF); end
  endtask

  task automatic test_stall();
    goto_pc(32'h3020);
    for (int i = 0; i < 3; i++) begin
      bus.stall     = 1'b1;
      bus.br_taken  = (i == 1);
      bus.br_target = 32'h3300;
      #1;
      n_cmp++; if (bus.pcF !== 32'h3020) begin n_bad++; $display("FAIL stall_pcF[%0d]: got %h expected 00003020", i, bus.pcF); end
      tick();
    end
    idle_inputs();
    #1;
    n_cmp++; if (bus.pcF !== 32'h3020) begin n_bad++; $display("FAIL stall_hold_pcF: got %h expected 00003020", bus.pcF); end
    tick();
    n_cmp++; if (bus.pcF !== 32'h3024) begin n_bad++; $display("FAIL stall_release_pcF: got %h expected 00003024", bus.pcF); end
  endtask

  task automatic test_exc_eret();
    goto_pc(32'h3040);
    bus.exc_req = 1'b1;
    bus.eret_d  = 1'b1;
    bus.stall   = 1'b1;
    bus.epc     = 32'h3044;
    tick();
    idle_inputs();
    #1;
    n_cmp++; if (bus.pcF !== HANDLER_PC) begin n_bad++; $display("FAIL exc_pcF: got %h expected %h", bus.pcF, HANDLER_PC); end
    bus.eret_d = 1'b1;
    bus.epc    = 32'h3044;
    bus.jmp_d  = 1'b1;
    #1;
    n_cmp++; if (bus.insF !== 32'h0) begin n_bad++; $display("FAIL eret_insF: got %h expected 0", bus.insF); end
    n_cmp++; if (bus.bdF !== 1'b0) begin n_bad++; $display("FAIL eret_bdF: got %b expected 0", bus.bdF); end
    tick();
    idle_inputs();
    #1;
    n_cmp++; if (bus.pcF !== 32'h3044) begin n_bad++; $display("FAIL eret_pcF: got %h expected 00003044", bus.pcF); end
    bus.eret_d    = 1'b1;
    bus.epc       = 32'h3500;
    bus.br_taken  = 1'b1;
    bus.br_target = 32'h3600;
    tick();
    idle_inputs();
    #1;
    n_cmp++; if (bus.pcF !== 32'h3500) begin n_bad++; $display("FAIL eret_vs_br_pcF: got %h expected 00003500", bus.pcF); end
    bus.exc_req = 1'b1;
    bus.stall   = 1'b1;
    tick();
    idle_inputs();
    #1;
    n_cmp++; if (bus.pcF !== HANDLER_PC) begin n_bad++; $display("FAIL exc_stall_pcF: got %h expected %h", bus.pcF, HANDLER_PC); end
  endtask

  task automatic test_fetch_fault();
    goto_pc(32'h3102);
    n_cmp++; if (bus.pcF !== 32'h3102) begin n_bad++; $display("FAIL misal_pcF: got %h expected 00003102", bus.pcF); end
    n_cmp++; if (bus.execF !== 4'd4) begin n_bad++; $display("FAIL misal_execF: got %h expected 4", bus.execF); end
    n_cmp++; if (bus.insF !== 32'h0) begin n_bad++; $display("FAIL misal_insF: got %h expected 0", bus.insF); end
    goto_pc(32'h6FFC);
    n_cmp++; if (bus.execF !== 4'd0) begin n_bad++; $display("FAIL limit_execF: got %h expected 0", bus.execF); end
    n_cmp++; if (bus.insF !== FIXED_WORD) begin n_bad++; $display("FAIL limit_insF: got %h expected %h", bus.insF, FIXED_WORD); end
    tick();
    n_cmp++; if (bus.pcF !== 32'h7000) begin n_bad++; $display("FAIL over_pcF: got %h expected 00007000", bus.pcF); end
    n_cmp++; if (bus.execF !== 4'd4) begin n_bad++; $display("FAIL over_execF: got %h expected 4", bus.execF); end
    n_cmp++; if (bus.insF !== 32'h0) begin n_bad++; $display("FAIL over_insF: got %h expected 0", bus.insF); end
    bus.eret_d = 1'b1;
    bus.epc    = 32'h3000;
    #1;
    n_cmp++; if (bus.execF !== 4'd0) begin n_bad++; $display("FAIL eret_squash_execF: got %h expected 0", bus.execF); end
    tick();
    goto_pc(32'h2FFC);
    n_cmp++; if (bus.execF !== 4'd4) begin n_bad++; $display("FAIL under_execF: got %h expected 4", bus.execF); end
    goto_pc(32'hFFFF_FFFC);
    tick();
    n_cmp++; if (bus.pcF !== 32'h0) begin n_bad++; $display("FAIL wrap_pcF: got %h expected 0", bus.pcF); end
    n_cmp++; if (bus.execF !== 4'd4) begin n_bad++; $display("FAIL wrap_execF: got %h expected 4", bus.execF); end
  endtask

  task automatic test_reset_mid();
    goto_pc(32'h3400);
    reset         = 1'b1;
    bus.br_taken  = 1'b1;
    bus.br_target = 32'h3200;
    bus.stall     = 1'b1;
    tick();
    idle_inputs();
    #1;
    n_cmp++; if (bus.pcF !== RESET_PC) begin n_bad++; $display("FAIL reset_mid_pcF: got %h expected %h", bus.pcF, RESET_PC); end
  endtask

  task automatic test_random();
    logic [31:0] e_ins;
    logic [3:0]  e_exc;
    logic        e_bd;
    fixed_en = 1'b0;
    for (int i = 0; i < 400; i++) begin
      reset         = ($urandom % 40) == 0;
      bus.exc_req   = ($urandom % 16) == 0;
      bus.eret_d    = ($urandom % 12) == 0;
      bus.stall     = ($urandom % 4) == 0;
      bus.jmp_d     = ($urandom % 3) == 0;
      bus.br_taken  = ($urandom % 3) == 0;
      bus.br_target = (($urandom % 5) == 0) ? $urandom : IMEM_BASE + 4 * $urandom_range(0, 4095);
      bus.epc       = (($urandom % 5) == 0) ? $urandom : IMEM_BASE + 4 * $urandom_range(0, 4095);
      #1;
      e_bd  = bus.jmp_d && !bus.eret_d;
      e_exc = (!bus.eret_d && bad_addr(mpc)) ? 4'd4 : 4'd0;
      e_ins = (bus.eret_d || bad_addr(mpc)) ? 32'h0 : mem_word(mpc);
      n_cmp++; if (bus.pcF !== mpc) begin n_bad++; $display("FAIL rnd_pcF[%0d]: got %h expected %h", i, bus.pcF, mpc); end
      n_cmp++; if (bus.imem_addr !== mpc) begin n_bad++; $display("FAIL rnd_imem_addr[%0d]: got %h expected %h", i, bus.imem_addr, mpc); end
      n_cmp++; if (bus.insF !== e_ins) begin n_bad++; $display("FAIL rnd_insF[%0d]: got %h expected %h", i, bus.insF, e_ins); end
      n_cmp++; if (bus.bdF !== e_bd) begin n_bad++; $display("FAIL rnd_bdF[%0d]: got %b expected %b", i, bus.bdF, e_bd); end
      n_cmp++; if (bus.execF !== e_exc) begin n_bad++; $display("FAIL rnd_execF[%0d]: got %h expected %h", i, bus.execF, e_exc); end
      tick();
    end
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    fixed_en = 1'b1;
    mpc      = 32'h0;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_sequential();
    test_branch();
    test_stall();
    test_exc_eret();
    test_fetch_fault();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- IF-stage instruction fetch unit; the producer side of the IF/ID pipeline register.
- Owns the architectural fetch PC and drives the instruction-memory address.
- Presents pcF, insF, bdF and execF, the exact fields the IF/ID register captures when its write enable is high.
- Applies next-PC selection with fixed priority: exception entry, eret return, stall, branch/jump redirect, sequential.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- HANDLER_PC, 32'h0000_4180, exception handler entry address.
- IMEM_BASE, 32'h0000_3000, lowest legal fetch address (inclusive).
- IMEM_LIMIT, 32'h0000_6FFC, highest legal fetch address (inclusive).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hazard stall; the IF/ID write enable is its complement.
- exc_req  input  1  exception/interrupt taken this cycle (from CP0).
- eret_d  input  1  eret instruction is in ID and valid.
- epc  input  32  return address for eret.
- jmp_d  input  1  ID holds a branch/jump (taken or not); marks the IF instruction as a delay slot.
- br_taken  input  1  ID branch/jump resolved taken.
- br_target  input  32  redirect target for a taken branch/jump.
- imem_addr  output  32  instruction memory address; equal to pcF.
- imem_rdata  input  32  instruction word; combinational read of imem_addr.
- pcF  output  32  current fetch PC (register).
- insF  output  32  fetched instruction, or 0 when squashed.
- bdF  output  1  IF instruction is in a branch delay slot.
- execF  output  4  fetch exception code: 0 none, 4 AdEL.

Behaviour:
- Reset:
  - pc <= RESET_PC on the first rising edge with reset=1. Reset overrides every other input.
  - While reset is held, outputs follow the reset PC: pcF=RESET_PC, imem_addr=RESET_PC, execF=0.
  - Reset asserted mid-redirect or mid-stall discards all pending intent.
- Next PC, evaluated every cycle by priority:
  1. exc_req: pc <= HANDLER_PC, regardless of stall.
  2. eret_d: pc <= epc, regardless of stall.
  3. stall: pc holds. A br_taken seen during stall is ignored, because ID re-presents the same branch next cycle.
  4. br_taken: pc <= br_target.
  5. Otherwise: pc <= pc + 4, modulo 2^32 (wraps silently).
- Fetch check (combinational on pc):
  - misaligned = pc[1:0] != 0.
  - out_of_range = pc < IMEM_BASE or pc > IMEM_LIMIT, unsigned compare.
  - If either holds: execF=4 (AdEL) and insF=0. Otherwise execF=0 and insF=imem_rdata.
- Delay slot:
  - bdF = jmp_d, combinational.
  - bdF is forced 0 when eret_d=1, because the instruction after eret is squashed and is not a delay slot.
- eret squash:
  - When eret_d=1, insF=0 and execF=0. The sequential instruction behind eret never executes and never faults.
- exc_req does not alter the current outputs; the pipeline flush is performed by the IF/ID register control.
- Latency:
  - Redirect (exc_req, eret_d or br_taken) takes effect on pcF one cycle after assertion.
  - Zero-latency combinational path from imem_rdata to insF.
- Simultaneous events:
  - exc_req with eret_d: handler wins.
  - eret_d with br_taken: epc wins.
  - stall with br_taken: hold.
  - exc_req with stall: handler.
- A misaligned br_target or epc is loaded unchanged; the fault is reported as execF=4 on the following cycle.

Test Plan:
- Reset 2 cycles, then 3 free cycles -> pcF = 3000, 3004, 3008, 300C. With imem_rdata=32'h2408_0001, insF=32'h2408_0001, execF=0.
- pc=3010, br_taken=1, br_target=3100, jmp_d=1 for one cycle -> bdF=1 that cycle; next pcF=3100, then 3104.
- pc=3020, stall=1 for 3 cycles with br_taken=1 in the middle cycle -> pcF stays 3020. On release with br_taken=0, pcF=3024.
- br_target=3102 -> next cycle pcF=3102, execF=4, insF=0. Separately, pc reaching 7000 -> execF=4.
- exc_req=1, eret_d=1, stall=1 together at pc=3040 -> next pcF=4180. A later eret_d=1 with epc=3044 -> insF=0, bdF=0 that cycle; next pcF=3044.
- reset asserted the same cycle as br_taken=1 (target 3200) -> next pcF=3000.
